// File: rtl/fullxor_pkg.sv
// Shared sizing helpers and the default share-word type for the masked XOR compressor.
package fullxor_pkg;

    localparam int unsigned K_WIDTH_DEF = 32;

    typedef logic [K_WIDTH_DEF-1:0] share_t;

    // Number of registered tree layers (pipeline latency).
    function automatic int unsigned f_layers(input int unsigned n);
        return $clog2(n);
    endfunction

    // Random words consumed by the refresh stage.
    function automatic int unsigned f_randnum(input int unsigned n);
        int unsigned log_k;
        log_k = $clog2(n + 1) - 1;
        return log_k * (1 << (log_k - 1)) + n - (1 << log_k);
    endfunction

    // Element count entering layer l: ceil(n / 2^l).
    function automatic int unsigned f_layer_width(input int unsigned n, input int unsigned l);
        return (n + (1 << l) - 1) >> l;
    endfunction

endpackage

// File: rtl/fxor_layer.sv
// One XOR-tree layer: pairs adjacent words into registers, odd leftover passes through.
module fxor_layer #(
    parameter int unsigned K_WIDTH = 32,
    parameter int unsigned IN_CNT  = 3
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  vld_i,
    input  logic [IN_CNT*K_WIDTH-1:0]             data_i,
    output logic                                  vld_o,
    output logic [((IN_CNT+1)/2)*K_WIDTH-1:0]     data_o
);

    localparam int unsigned OUT_CNT = (IN_CNT + 1) / 2;

    logic [OUT_CNT*K_WIDTH-1:0] fold_c;
    logic [OUT_CNT*K_WIDTH-1:0] data_d, data_q;
    logic                       vld_d, vld_q;

    for (genvar m = 0; m < OUT_CNT; m++) begin : g_fold
        if (2 * m + 1 < IN_CNT) begin : g_pair
            assign fold_c[m*K_WIDTH +: K_WIDTH] = data_i[(2*m)*K_WIDTH +: K_WIDTH]
                                                ^ data_i[(2*m+1)*K_WIDTH +: K_WIDTH];
        end else begin : g_pass
            assign fold_c[m*K_WIDTH +: K_WIDTH] = data_i[(2*m)*K_WIDTH +: K_WIDTH];
        end
    end

    // Data loads only behind a valid word so bubbles leave the layer untouched.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_i;
        if (vld_i) begin
            data_d = fold_c;
        end
    end

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;

endmodule

// File: rtl/full_xor.sv
// Masked-share XOR compressor: refresh shares with fresh randomness, then a pipelined XOR tree.
// Optional FULLXOR_ZERO_INVALID_EN forces o_z to zero whenever o_dvld is low.
module full_xor
    import fullxor_pkg::*;
#(
    parameter int unsigned K_WIDTH  = 32,
    parameter int unsigned N_SHARES = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              i_dvld,
    input  logic                              i_rvld,
    input  logic [K_WIDTH*f_randnum(N_SHARES)-1:0] i_n,
    input  logic [K_WIDTH*N_SHARES-1:0]       i_x,
    output logic [K_WIDTH-1:0]                o_z,
    output logic                              o_dvld
);

    localparam int unsigned LAYERS  = f_layers(N_SHARES);
    localparam int unsigned RANDNUM = f_randnum(N_SHARES);

    logic                          accept_c;
    logic [K_WIDTH*N_SHARES-1:0]   refresh_c;
    logic [K_WIDTH-1:0]            last_c;

    assign accept_c = i_dvld & i_rvld;

    // Each random word lands on two neighbouring shares, so it cancels in the total XOR.
    always_comb begin
        refresh_c = i_x;
        for (int unsigned k = 0; k < RANDNUM; k++) begin
            refresh_c[(k % N_SHARES)*K_WIDTH +: K_WIDTH] =
                refresh_c[(k % N_SHARES)*K_WIDTH +: K_WIDTH] ^ i_n[k*K_WIDTH +: K_WIDTH];
            refresh_c[((k + 1) % N_SHARES)*K_WIDTH +: K_WIDTH] =
                refresh_c[((k + 1) % N_SHARES)*K_WIDTH +: K_WIDTH] ^ i_n[k*K_WIDTH +: K_WIDTH];
        end
    end

    for (genvar l = 0; l < LAYERS; l++) begin : g_layer
        localparam int unsigned IN_CNT  = f_layer_width(N_SHARES, l);
        localparam int unsigned OUT_CNT = f_layer_width(N_SHARES, l + 1);

        logic [OUT_CNT*K_WIDTH-1:0] data;
        logic                       vld;

        if (l == 0) begin : g_first
            fxor_layer #(
                .K_WIDTH (K_WIDTH),
                .IN_CNT  (IN_CNT)
            ) u_layer (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .vld_i  (accept_c),
                .data_i (refresh_c),
                .vld_o  (vld),
                .data_o (data)
            );
        end else begin : g_rest
            fxor_layer #(
                .K_WIDTH (K_WIDTH),
                .IN_CNT  (IN_CNT)
            ) u_layer (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .vld_i  (g_layer[l-1].vld),
                .data_i (g_layer[l-1].data),
                .vld_o  (vld),
                .data_o (data)
            );
        end
    end

    assign last_c = g_layer[LAYERS-1].data;
    assign o_dvld = g_layer[LAYERS-1].vld;

`ifdef FULLXOR_ZERO_INVALID_EN
    assign o_z = o_dvld ? last_c : '0;
`else
    assign o_z = last_c;
`endif

endmodule

// File: tb/tb_full_xor.sv
// Directed self-checking bench for full_xor (N_SHARES=3, K_WIDTH=32, latency 2).
module tb_full_xor;

    localparam int unsigned K = 32;
    localparam int unsigned N = 3;
    localparam int unsigned R = 2;

    logic           clk_i;
    logic           rst_ni;
    logic           i_dvld;
    logic           i_rvld;
    logic [K*R-1:0] i_n;
    logic [K*N-1:0] i_x;
    logic [K-1:0]   o_z;
    logic           o_dvld;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [K-1:0] prev_exp;
    logic [K-1:0] cur_exp;
    logic [K-1:0] bubble_z;

    full_xor #(.K_WIDTH(K), .N_SHARES(N)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_dvld (i_dvld),
        .i_rvld (i_rvld),
        .i_n    (i_n),
        .i_x    (i_x),
        .o_z    (o_z),
        .o_dvld (o_dvld)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // 1. reset
        rst_ni = 1'b1;
        i_dvld = 1'b0;
        i_rvld = 1'b0;
        i_n    = '0;
        i_x    = '0;
        step();
        step();
        check("reset_z", o_z, 32'h0);
        check("reset_dvld", 32'(o_dvld), 32'h0);
        rst_ni = 1'b0;
        step();

        // 2. basic vector
        i_x    = {32'h0000_00FF, 32'h0000_0F0F, 32'hFFFF_0000};
        i_n    = {32'h1234_5678, 32'hDEAD_BEEF};
        i_dvld = 1'b1;
        i_rvld = 1'b1;
        step();
        i_dvld = 1'b0;
        i_rvld = 1'b0;
        check("basic_lat1_dvld", 32'(o_dvld), 32'h0);
        step();
        check("basic_z", o_z, 32'hFFFF_0FF0);
        check("basic_dvld", 32'(o_dvld), 32'h1);
        step();
        check("basic_after_dvld", 32'(o_dvld), 32'h0);
`ifdef FULLXOR_ZERO_INVALID_EN
        check("basic_after_z", o_z, 32'h0);
`else
        check("basic_after_z", o_z, 32'hFFFF_0FF0);
`endif

        // 3. random streaming against a two-deep model
        i_dvld   = 1'b1;
        i_rvld   = 1'b1;
        prev_exp = '0;
        for (int c = 0; c < 100; c++) begin
            i_x     = {$urandom(), $urandom(), $urandom()};
            i_n     = {$urandom(), $urandom()};
            cur_exp = i_x[31:0] ^ i_x[63:32] ^ i_x[95:64];
            step();
            if (c >= 1) begin
                check("stream_z", o_z, prev_exp);
                check("stream_dvld", 32'(o_dvld), 32'h1);
            end
            prev_exp = cur_exp;
        end

        // 4. randomness independence
        i_x = {32'h1234_5678, 32'h0F0F_0F0F, 32'hA5A5_A5A5};
        for (int i = 0; i < 10; i++) begin
            i_n = {$urandom(), $urandom()};
            step();
            if (i >= 1) check("indep_z", o_z, 32'hB89E_FCD2);
        end

        // 5. one-cycle bubble from i_rvld low; the dropped data must not appear
        i_rvld = 1'b0;
        i_x    = {32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        step();
        check("bubble_pre_dvld", 32'(o_dvld), 32'h1);
        check("bubble_pre_z", o_z, 32'hB89E_FCD2);
        i_rvld = 1'b1;
        i_x    = {32'h0000_0004, 32'h0000_0002, 32'h0000_0001};
        step();
`ifdef FULLXOR_ZERO_INVALID_EN
        bubble_z = 32'h0;
`else
        bubble_z = 32'hB89E_FCD2;
`endif
        check("bubble_dvld", 32'(o_dvld), 32'h0);
        check("bubble_z", o_z, bubble_z);
        step();
        check("bubble_post_dvld", 32'(o_dvld), 32'h1);
        check("bubble_post_z", o_z, 32'h0000_0007);

        // 6. mid-stream reset
        i_x = {32'h0000_0000, 32'h0000_BEEF, 32'hDEAD_0000};
        step();
        rst_ni = 1'b1;
        #1;
        check("midrst_z", o_z, 32'h0);
        check("midrst_dvld", 32'(o_dvld), 32'h0);
        step();
        rst_ni = 1'b0;
        step();
        check("postrst_lat1_dvld", 32'(o_dvld), 32'h0);
        step();
        check("postrst_dvld", 32'(o_dvld), 32'h1);
        check("postrst_z", o_z, 32'hDEAD_BEEF);

        i_dvld = 1'b0;
        i_rvld = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
